interp_stream_port: RTL and testbench
=====================================

# interp_stream_port

Parametrised byte-serial output port between the pipelined processor's load path and the external interpreter. It captures every word the CPU loads while the COM flag is asserted and buffers it in an internal FIFO. Each word is then streamed out one byte at a time on an 8-bit bus, qualified by a slow strobe (`clk_out`). It replaces the fixed single-word interpreter link and adds configurable word width, buffering depth, byte order, overflow reporting and an optional acknowledge handshake.

## Interface
- `DATA_W`, 32, loaded word width; multiple of 8, 8..64; BYTES = DATA_W/8
- `FIFO_DEPTH`, 8, words buffered; power of 2, ≥2
- `STROBE_CYC`, 4, clk cycles per strobe phase (high and low); ≥1
- `MSB_FIRST`, 0, 0 = byte 0 is ReadData[7:0]; 1 = byte 0 is ReadData[DATA_W-1:DATA_W-8]
- `ACK_MODE`, 0, 0 = timed strobe; 1 = strobe high held until `ext_ack`

Ports:
- `clk`  in  1  single system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `MemtoReg`  in  1  CPU memory-stage load qualifier
- `COM`  in  1  interpreter-communication flag from CPU
- `ReadData`  in  DATA_W  data memory read word
- `ext_ack`  in  1  interpreter byte acknowledge (ignored when ACK_MODE=0)
- `clk_out`  out  1  byte strobe to interpreter
- `ReadDataOut`  out  8  current byte
- `busy`  out  1  FIFO non-empty or serializer not IDLE
- `overflow`  out  1  sticky: a capture was dropped
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  words currently buffered

## Operation
- Capture: `COM && MemtoReg` high at a rising edge → push `ReadData` into the FIFO.
  - FIFO full: the word is dropped, FIFO is unchanged, `overflow` sets and stays set until reset.
- Push and pop in the same cycle are both performed. A push into a full FIFO is dropped even when a pop occurs in that same cycle; fullness is judged before the pop.
- Serializer FSM states:
  - IDLE: if FIFO non-empty, pop into the shift register, set byte_idx=0, go to SETUP.
  - SETUP (1 cycle): `ReadDataOut` ← byte[byte_idx], `clk_out`=0; go to HIGH.
  - HIGH: `clk_out`=1.
    - ACK_MODE=0: lasts STROBE_CYC cycles.
    - ACK_MODE=1: lasts at least 1 cycle, until `ext_ack` is sampled high.
    - Then go to LOW.
  - LOW: `clk_out`=0 for STROBE_CYC cycles. Then:
    - byte_idx<BYTES-1: byte_idx++, go to SETUP.
    - byte_idx=BYTES-1: go to IDLE.
- `ReadDataOut` changes only on entry to SETUP and holds through HIGH/LOW and into IDLE, retaining its last value.
- Byte order is selected by MSB_FIRST. Bytes of one word are never interleaved with another word.
- Phase counter wrap: it reloads at each phase entry and never free-runs.
- `fifo_level` = number of stored words, 0..FIFO_DEPTH. Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (synchronous) result: `clk_out`=0, `ReadDataOut`=0, `overflow`=0, `busy`=0, `fifo_level`=0, FSM=IDLE, FIFO emptied.
- Reset mid-word aborts the transfer immediately; buffered data is discarded.
- Latency from capture at edge N into an empty, idle port:
  - `fifo_level`=1 after edge N.
  - Pop at edge N+1.
  - `ReadDataOut` valid after edge N+2.
  - `clk_out` high after edge N+3.
- ACK_MODE=0 timing:
  - Each byte takes 1+2·STROBE_CYC cycles.
  - Each word takes BYTES·(1+2·STROBE_CYC)+1 cycles, including IDLE.
  - Back-to-back words: IDLE lasts exactly 1 cycle.
- ACK_MODE=1: `ext_ack` is sampled only in HIGH. If it is high on the first HIGH cycle, HIGH lasts 1 cycle.
- `busy` is registered and reflects state/FIFO after each edge. It is high from the edge after capture until the edge on which the FSM returns to IDLE with the FIFO empty.

## Test plan
- Reset, single capture (defaults): capture 0xA1B2C3D4 → `ReadDataOut` sequence D4, C3, B2, A1; each byte has 4 cycles `clk_out` high, 4 low; first rise 3 cycles after capture; `busy` drops 37 cycles after the pop.
- MSB_FIRST=1, DATA_W=16: capture 0x1234 → bytes 12, 34; then IDLE.
- Overflow (FIFO_DEPTH=4): 6 consecutive captures 1..6 → `fifo_level` peaks at 4; word 6 dropped (one pop frees space first, so word 5 is kept); `overflow`=1; output words 1, 2, 3, 4, 5 only.
- Simultaneous push/pop: capture on the exact cycle the FSM pops from a FIFO holding 1 word → `fifo_level` stays 1; no data loss.
- ACK_MODE=1: hold `ext_ack`=0 for 20 cycles → `clk_out` stays high; pulse `ext_ack` → `clk_out` low next cycle, LOW lasts 4 cycles.
- Reset mid-stream: assert `reset` during byte 2 with 3 words buffered → next cycle all outputs 0, `fifo_level`=0; no further strobes.

Source files
------------

// File: rtl/interp_stream_port.sv
// Byte-serial interpreter port: captures CPU loads while COM is set, buffers them,
// and streams each word out one byte per clk_out strobe.
module interp_stream_port #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int STROBE_CYC = 4,
  parameter int MSB_FIRST  = 0,
  parameter int ACK_MODE   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          MemtoReg,
  input  logic                          COM,
  input  logic [DATA_W-1:0]             ReadData,
  input  logic                          ext_ack,
  output logic                          clk_out,
  output logic [7:0]                    ReadDataOut,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BYTES = DATA_W / 8;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CW    = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);
  localparam logic [CW-1:0] CNT_LD   = CW'(STROBE_CYC - 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt, sel;
  logic [BYTES-1:0][7:0] word_q;
  logic [7:0] cur_byte;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic push, full, push_ok, pop;

  // Fullness is judged on the pre-edge level, so a same-cycle pop never rescues a push.
  assign push    = COM && MemtoReg;
  assign full    = (fifo_level == FULL_LVL);
  assign push_ok = push && !full;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= ReadData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      fifo_level <= fifo_level + (AW+1)'(push_ok) - (AW+1)'(pop);
      if (push && full) overflow <= 1'b1;
    end
  end

  assign sel      = (MSB_FIRST != 0) ? LAST_IDX - idx : idx;
  assign cur_byte = word_q[sel];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level != '0) begin
          pop       = 1'b1;
          idx_nxt   = '0;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = HIGH;
        cnt_nxt   = CNT_LD;
      end
      HIGH: begin
        if (ACK_MODE != 0) begin
          if (ext_ack) begin
            state_nxt = LOW;
            cnt_nxt   = CNT_LD;
          end
        end else if (cnt == '0) begin
          state_nxt = LOW;
          cnt_nxt   = CNT_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      LOW: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (idx == LAST_IDX) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = SETUP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the current state, so the bus settles a cycle before the strobe rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      word_q      <= '0;
      clk_out     <= 1'b0;
      ReadDataOut <= '0;
      busy        <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      if (pop) word_q <= mem[rptr];
      clk_out <= (state == HIGH);
      if (state == SETUP) ReadDataOut <= cur_byte;
      busy    <= (state != IDLE) || (fifo_level != '0);
    end
  end

endmodule

// File: tb/tb_interp_stream_port.sv
// Bench for interp_stream_port: default instance checked every cycle against a timing-formula
// model; 16-bit MSB-first / depth-4 instance and ACK-mode instance checked with directed sequences.
module tb_interp_stream_port;

  localparam int SC = 4;
  localparam int NB = 4;
  localparam int BC = 1 + 2*SC;
  localparam int D0 = 8;

  logic clk;
  logic rst0, mr0, com0, ack0, clko0, busy0, ovf0;
  logic [31:0] rd0;
  logic [7:0]  dout0;
  logic [3:0]  lvl0;
  logic rst1, mr1, com1, ack1, clko1, busy1, ovf1;
  logic [15:0] rd1;
  logic [7:0]  dout1;
  logic [2:0]  lvl1;
  logic rst2, mr2, com2, ack2, clko2, busy2, ovf2;
  logic [31:0] rd2;
  logic [7:0]  dout2;
  logic [3:0]  lvl2;

  interp_stream_port u0 (
    .clk(clk), .reset(rst0), .MemtoReg(mr0), .COM(com0), .ReadData(rd0), .ext_ack(ack0),
    .clk_out(clko0), .ReadDataOut(dout0), .busy(busy0), .overflow(ovf0), .fifo_level(lvl0));

  interp_stream_port #(.DATA_W(16), .FIFO_DEPTH(4), .MSB_FIRST(1)) u1 (
    .clk(clk), .reset(rst1), .MemtoReg(mr1), .COM(com1), .ReadData(rd1), .ext_ack(ack1),
    .clk_out(clko1), .ReadDataOut(dout1), .busy(busy1), .overflow(ovf1), .fifo_level(lvl1));

  interp_stream_port #(.ACK_MODE(1)) u2 (
    .clk(clk), .reset(rst2), .MemtoReg(mr2), .COM(com2), .ReadData(rd2), .ext_ack(ack2),
    .clk_out(clko2), .ReadDataOut(dout2), .busy(busy2), .overflow(ovf2), .fifo_level(lvl2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference for u0: a word popped at edge P occupies the serializer for NB*BC edges;
  // byte k appears on the bus after edge P+1+k*BC and strobes high for SC cycles from P+2+k*BC.
  logic [31:0] mq[$];
  longint e = 0, P = 0;
  bit pv = 0;
  logic [31:0] cur;
  logic m_clk = 0, m_busy = 0, m_ovf = 0;
  logic [7:0] m_dout = 0;

  function automatic bit act(longint x);
    return pv && x >= P && x < P + NB*BC;
  endfunction

  task automatic step0();
    bit pop, full, cap;
    longint d;
    e++;
    if (rst0) begin
      mq.delete(); pv = 0; m_clk = 0; m_dout = 0; m_busy = 0; m_ovf = 0;
      return;
    end
    cap    = com0 && mr0;
    m_busy = (mq.size() != 0) || act(e-1);
    pop    = (mq.size() != 0) && !act(e-1);
    full   = (mq.size() == D0);
    if (cap && full) m_ovf = 1;
    if (pop) begin cur = mq.pop_front(); P = e; pv = 1; end
    if (cap && !full) mq.push_back(rd0);
    d = e - P - 1;
    if (pv && d >= 0 && d % BC == 0 && d / BC < NB) m_dout = cur[8*int'(d/BC) +: 8];
    d = e - P - 2;
    m_clk = pv && d >= 0 && d < NB*BC && (d % BC) < SC;
  endtask

  logic [7:0] got0[$], got1[$], got2[$];
  logic pc0 = 0, pc1 = 0, pc2 = 0;
  int max1 = 0;

  task automatic tick();
    @(posedge clk);
    step0();
    @(negedge clk);
    chk("u0_clk_out", clko0, m_clk);
    chk("u0_dout", dout0, m_dout);
    chk("u0_busy", busy0, m_busy);
    chk("u0_overflow", ovf0, m_ovf);
    chk("u0_level", lvl0, mq.size());
    if (clko0 && !pc0) got0.push_back(dout0);
    if (clko1 && !pc1) got1.push_back(dout1);
    if (clko2 && !pc2) got2.push_back(dout2);
    pc0 = clko0; pc1 = clko1; pc2 = clko2;
    if (int'(lvl1) > max1) max1 = int'(lvl1);
  endtask

  task automatic drain(input int id, input int lim, input string tag, output int n);
    logic b;
    n = 0;
    do begin
      tick();
      n++;
      case (id)
        0: b = busy0;
        1: b = busy1;
        default: b = busy2;
      endcase
    end while (b && n < lim);
    chk(tag, b, 0);
  endtask

  task automatic chk_bytes(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int k = 0; k < exp.size() && k < got.size(); k++) chk(tag, got[k], exp[k]);
  endtask

  initial begin
    int n, z, hw;
    bit first;
    logic [7:0] exp_b[$];
    {rst0, rst1, rst2} = 3'b111;
    {mr0, com0, ack0, mr1, com1, ack1, mr2, com2, ack2} = '0;
    rd0 = '0; rd1 = '0; rd2 = '0;
    @(negedge clk);
    tick(); tick();
    chk("rst_clk1", clko1, 0); chk("rst_dout1", dout1, 0); chk("rst_busy1", busy1, 0);
    chk("rst_ovf1", ovf1, 0);  chk("rst_lvl1", lvl1, 0);
    chk("rst_clk2", clko2, 0); chk("rst_dout2", dout2, 0); chk("rst_busy2", busy2, 0);
    chk("rst_ovf2", ovf2, 0);  chk("rst_lvl2", lvl2, 0);
    {rst0, rst1, rst2} = 3'b000;
    tick();

    // single capture, default configuration
    got0.delete();
    com0 = 1; mr0 = 1; rd0 = 32'hA1B2C3D4;
    tick();
    chk("cap_level", lvl0, 1); chk("cap_busy", busy0, 0);
    com0 = 0; mr0 = 0;
    tick();
    chk("pop_level", lvl0, 0); chk("pop_busy", busy0, 1);
    tick();
    chk("setup_dout", dout0, 8'hD4); chk("setup_clk", clko0, 0);
    tick();
    chk("first_rise", clko0, 1);
    drain(0, 100, "single_timeout", n);
    chk("busy_drop_cycles", n + 2, 37);
    exp_b = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    chk_bytes("single_bytes", got0, exp_b);

    // push on the exact cycle the serializer pops
    got0.delete();
    com0 = 1; mr0 = 1; rd0 = 32'h11223344;
    tick();
    rd0 = 32'h55667788;
    tick();
    chk("pushpop_level", lvl0, 1);
    com0 = 0; mr0 = 0;
    drain(0, 200, "pushpop_timeout", n);
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    chk_bytes("pushpop_bytes", got0, exp_b);

    // randomized traffic with alternating light and bursty capture rates
    for (int i = 0; i < 2500; i++) begin
      com0 = ($urandom_range(0, 3) != 0);
      mr0  = ($urandom_range(0, (i % 500 < 250) ? 40 : 5) == 0);
      rd0  = $urandom;
      ack0 = $urandom_range(0, 1);
      rst0 = ($urandom_range(0, 699) == 0);
      tick();
    end
    {com0, mr0, ack0, rst0} = '0;

    // reset during byte 2 with three words buffered
    rst0 = 1; tick(); rst0 = 0;
    for (int k = 0; k < 4; k++) begin
      com0 = 1; mr0 = 1; rd0 = 32'hC0DE0000 + k;
      tick();
    end
    com0 = 0; mr0 = 0;
    chk("mid_level", lvl0, 3);
    for (int k = 0; k < 9; k++) tick();
    rst0 = 1; tick(); rst0 = 0;
    chk("mid_rst_clk", clko0, 0); chk("mid_rst_dout", dout0, 0); chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_ovf", ovf0, 0);  chk("mid_rst_level", lvl0, 0);
    got0.delete();
    for (int k = 0; k < 80; k++) tick();
    chk("mid_no_strobes", got0.size(), 0);
    chk("mid_idle_busy", busy0, 0);

    // 16-bit MSB-first word
    got1.delete();
    com1 = 1; mr1 = 1; rd1 = 16'h1234;
    tick();
    com1 = 0; mr1 = 0;
    drain(1, 100, "msb_timeout", n);
    exp_b = '{8'h12, 8'h34};
    chk_bytes("msb_bytes", got1, exp_b);
    chk("msb_overflow", ovf1, 0);

    // overflow on the depth-4 FIFO
    got1.delete(); max1 = 0;
    for (int k = 1; k <= 6; k++) begin
      com1 = 1; mr1 = 1; rd1 = 16'(k);
      tick();
    end
    com1 = 0; mr1 = 0;
    drain(1, 300, "ovf_timeout", n);
    chk("ovf_peak_level", max1, 4);
    chk("ovf_sticky", ovf1, 1);
    exp_b.delete();
    for (int k = 1; k <= 5; k++) begin exp_b.push_back(8'h00); exp_b.push_back(8'(k)); end
    chk_bytes("ovf_bytes", got1, exp_b);

    // acknowledge handshake
    got2.delete();
    com2 = 1; mr2 = 1; rd2 = 32'hCAFEF00D;
    tick();
    com2 = 0; mr2 = 0;
    n = 0;
    do begin tick(); n++; end while (!clko2 && n < 10);
    chk("ack_first_rise", clko2, 1);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("ack_hold_high", clko2, 1);
    end
    ack2 = 1; tick(); ack2 = 0;
    tick();
    chk("ack_fall", clko2, 0);
    z = 1;
    do begin tick(); if (!clko2) z++; end while (!clko2 && z < 20);
    // low samples span the LOW phase plus the one-cycle SETUP of the next byte
    chk("ack_low_cycles", z, SC + 1);
    chk("ack_byte1", dout2, 8'hF0);
    ack2 = 1;
    hw = 0; first = 1; n = 0;
    do begin
      tick(); n++;
      if (clko2) hw++;
      else begin
        if (hw > 0 && !first) chk("ack_width", hw, 1);
        if (hw > 0 || clko2 == 0) first = 0;
        hw = 0;
      end
    end while (busy2 && n < 200);
    chk("ack_timeout", busy2, 0);
    ack2 = 0;
    exp_b = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
    chk_bytes("ack_bytes", got2, exp_b);
    chk("ack_overflow", ovf2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
